ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
- Sits directly downstream of the PC-generation stage, between it, the instruction memory and decode.
- Accepts each PC and issues it as a word-aligned fetch request to instruction memory.
- Pairs each in-order memory response with its PC and buffers the (pc, instr) pairs in a small FIFO feeding decode.
- Handles flush on taken branch/jump by discarding queued entries and any in-flight responses.

Parameters:
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
MAX_OUT, 2, max outstanding imem requests (power of 2, <=DEPTH)
XLEN, 32, address/instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_in  in  XLEN  fetch address from PC stage
pc_valid  in  1  pc_in valid
pc_ready  out  1  PC accepted this cycle
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  {pc_in[XLEN-1:2],2'b00}
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid, in order, no backpressure, >=1 cycle after accept
imem_rsp_data  in  XLEN  instruction word
flush  in  1  discard all queued/in-flight fetches
id_valid  out  1  entry available to decode
id_pc  out  XLEN  PC of head entry
id_instr  out  XLEN  instruction of head entry
id_ready  in  1  decode consumes head

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: FIFO count, tag-queue count, outstanding count and drop count all 0; id_valid=0; id_pc=id_instr=0; imem_req_valid=0; pc_ready=0.
- Credit: credit = (fifo_count + outstanding) < DEPTH && outstanding < MAX_OUT.
- Request path is combinational:
  - imem_req_valid = pc_valid && credit && !flush && drop_cnt==0.
  - pc_ready = imem_req_valid && imem_req_ready.
- Accepted request pushes pc_in into the internal tag queue (depth MAX_OUT) and increments outstanding.
- Response handling:
  - drop_cnt==0: pops tag queue and pushes {tag_pc, imem_rsp_data} into the instruction FIFO; outstanding decrements.
  - drop_cnt>0: response is discarded and drop_cnt decrements.
- Decode handshake: id_valid = fifo not empty; pop on id_valid && id_ready. id_pc/id_instr are registered FIFO head outputs.
- Latency: response at cycle N -> id_valid at N+1 (no bypass).
- Simultaneous push, pop and request in one cycle are all legal; counts update by net effect.
- Full FIFO: credit prevents overflow; no response is ever dropped except under flush.
- Flush (synchronous, takes priority over push/pop/request that cycle):
  - Clears instruction FIFO and tag queue; id_valid=0 next cycle.
  - drop_cnt <= outstanding − (imem_rsp_valid ? 1 : 0).
  - A response arriving in the flush cycle is discarded.
  - New requests are blocked until drop_cnt==0 (prevents response mis-pairing).
- Flush while drop_cnt>0: drop_cnt unchanged except the normal decrement.
- Async reset mid-operation: all state cleared immediately. After reset the memory must not return stale responses (system requirement).
- Pointers wrap modulo DEPTH/MAX_OUT; counts are one bit wider than pointers.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty, drop_cnt==0 and imem_rsp_valid=1, the response is presented combinationally: id_valid=1, id_pc=tag head, id_instr=imem_rsp_data, same cycle.
  - If id_ready=1, the entry is not written to the FIFO.
  - Otherwise it is written normally.
- Not defined: id_* come only from FIFO registers; 1-cycle response-to-decode latency.

Decomposition:
- Package ifq_pkg: XLEN default, NOP encoding 32'h00000013, entry struct/width constant (2*XLEN).
- One sub-module: ifq_sync_fifo, parameterised width/depth with push/pop/flush/count. It is instantiated twice: as the instruction FIFO and as the tag queue.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 entries queued -> id_valid=0, imem_req_valid=0 immediately; after release the first pc_in=0x0 is issued with imem_req_addr=0x0.
- Streaming: pcs 0x0,0x4,0x8,0xC with imem_req_ready=1, 1-cycle memory, id_ready=1 -> decode sees (0x0,I0)…(0xC,I3) in order, one per cycle after fill, no bubbles.
- Backpressure: id_ready=0 with DEPTH=4 -> exactly 4 requests accepted, then pc_ready=0. One pop -> exactly one further request issued.
- Flush with 2 outstanding: flush at cycle T, responses at T+1 and T+2 -> both dropped, id_valid stays 0. New pc 0x100 accepted no earlier than T+3 and decoded as (0x100, its instr).
- Misaligned addr: pc_in=0x106 -> imem_req_addr=0x104, id_pc=0x106.
- Bypass: with IFQ_BYPASS_EN, FIFO empty, response at cycle N, id_ready=1 -> id_valid=1 at N and FIFO stays empty. Without the macro -> id_valid first at N+1.

Source files
------------

// File: rtl/ifq_pkg.sv
// ============================================================================
//  Module      : ifq_pkg
//  Description : Shared constants, entry layout and sizing helpers for the
//                instruction fetch queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ifq_pkg;

    localparam int          IFQ_XLEN    = 32;
    localparam logic [31:0] IFQ_NOP     = 32'h0000_0013;
    localparam int          IFQ_ENTRY_W = 2 * IFQ_XLEN;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] instr;
    } ifq_entry_t;

    // Occupancy counters are one bit wider than the pointers so "full" is representable.
    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ifq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifq_sync_fifo.sv
// ============================================================================
//  Module      : ifq_sync_fifo
//  Description : Register-based synchronous FIFO with flush; head is driven
//                straight from the storage registers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifq_sync_fifo
    import ifq_pkg::*;
#(
    parameter int WIDTH = IFQ_ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = ifq_ptr_w(DEPTH);
    localparam int CNT_W = ifq_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the occupancy is discarded.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ============================================================================
//  Module      : ifetch_queue
//  Description : Issues PCs as word-aligned imem requests, pairs in-order
//                responses with their PCs and queues them for decode.
//                Optional same-cycle response bypass: IFQ_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int XLEN    = IFQ_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    input  logic            id_ready
);

    localparam int FCNT_W  = ifq_cnt_w(DEPTH);
    localparam int OCNT_W  = ifq_cnt_w(MAX_OUT);
    localparam int ENTRY_W = 2 * XLEN;

    logic [FCNT_W-1:0]  fifo_count;
    logic [OCNT_W-1:0]  outstanding;
    logic [OCNT_W-1:0]  drop_cnt;
    logic [OCNT_W-1:0]  pending;
    logic [ENTRY_W-1:0] fifo_head;
    logic [XLEN-1:0]    tag_head;
    logic               credit;
    logic               drain_idle;
    logic               req_go;
    logic               rsp_take;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               bypass;

    // Tag queue occupancy is exactly the number of live outstanding requests.
    assign credit     = ((int'(fifo_count) + int'(outstanding)) < DEPTH)
                        && (int'(outstanding) < MAX_OUT);
    assign drain_idle = (drop_cnt == '0);

    assign req_go         = rst_n && pc_valid && credit && !flush && drain_idle;
    assign imem_req_valid = req_go;
    assign imem_req_addr  = {pc_in[XLEN-1:2], 2'b00};
    assign pc_ready       = req_go && imem_req_ready;

    assign rsp_take   = imem_rsp_valid && drain_idle && !flush;
    assign fifo_empty = (fifo_count == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = fifo_empty && drain_idle && imem_rsp_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign id_valid  = !fifo_empty || bypass;
    assign id_pc     = bypass ? tag_head      : fifo_head[ENTRY_W-1:XLEN];
    assign id_instr  = bypass ? imem_rsp_data : fifo_head[XLEN-1:0];
    assign fifo_push = rsp_take && !(bypass && id_ready);
    assign fifo_pop  = !fifo_empty && id_ready;

    ifq_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (pc_ready),
        .push_data (pc_in),
        .pop       (rsp_take),
        .head      (tag_head),
        .count     (outstanding)
    );

    ifq_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fifo_push),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // New requests are blocked while dropping, so outstanding and drop_cnt are
    // never both non-zero and their sum is the number of responses still owed.
    assign pending = drop_cnt + outstanding;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= pending - OCNT_W'(imem_rsp_valid && (pending != '0));
        end else if (imem_rsp_valid && !drain_idle) begin
            drop_cnt <= drop_cnt - OCNT_W'(1);
        end
    end

endmodule

`default_nettype wire
